stream_rotator: RTL
===================

Name: stream_rotator

Overview:
- Parametrised, pipelined successor to the fixed 24-bit cyclic shifter used in the WS2811 pixel path.
- Rotates a WIDTH-bit word left or right by a per-word amount, one rotate-by-2^k stage per register.
- Uses a valid/ready stream interface, so it sits between the pixel-word fetch and the WS2811 bit serializer.
- Sustains one word per clock under backpressure.

Parameters:
- WIDTH, 24, data word width in bits (>= 2).
- SHIFT_W, $clog2(WIDTH), width of the shift-amount port; derived, never overridden.

Ports:
- clkIN  input  1  system clock; all logic on its rising edge.
- rstIN  input  1  synchronous, active-high reset.
- dataIN  input  WIDTH  word to rotate.
- shiftIN  input  SHIFT_W  rotate amount.
- dirIN  input  1  0 = rotate left (MSB side), 1 = rotate right.
- validIN  input  1  upstream word valid.
- readyOUT  output  1  block can accept a word this cycle.
- dataOUT  output  WIDTH  rotated word.
- validOUT  output  1  dataOUT valid.
- readyIN  input  1  downstream accepts dataOUT.
- rangeErrOUT  output  1  qualifies dataOUT; the word carried an out-of-range shift.
- busyOUT  output  1  at least one pipeline stage holds a word.
- autoIN  input  1  present only with AUTO_ROTATE_EN; see below.

Behaviour:
- Transfers: input on validIN && readyOUT; output on validOUT && readyIN.
- Shift normalisation (combinational, before stage 0):
  - n = shiftIN.
  - If n >= WIDTH: effective amount e = 0 and the error bit is set.
  - Otherwise e = dirIN ? (n == 0 ? 0 : WIDTH - n) : n, as a left-rotate amount.
- Pipeline: SHIFT_W registered stages.
  - Stage k rotates left by 2^k when bit k of e is set.
  - Each stage carries {valid, data, e, err}.
- Latency: a word accepted in cycle t appears on validOUT in cycle t + SHIFT_W when not stalled (5 cycles for WIDTH = 24).
- Flow control: bubble-collapsing.
  - Stage k loads when it is empty or its contents move on in the same cycle.
  - readyOUT = !stage0.valid || stage0 advancing.
  - Throughput is 1 word/cycle while readyIN is high.
- Backpressure:
  - While validOUT && !readyIN, the last stage holds dataOUT and rangeErrOUT stable.
  - Upstream stages fill, then readyOUT deasserts.
  - Words are never dropped, duplicated or reordered.
- Simultaneous accept and emit with a full pipe: legal, no stall.
- Reset:
  - Every stage valid is cleared; dataOUT = 0, validOUT = 0, rangeErrOUT = 0, busyOUT = 0.
  - readyOUT = 0 while rstIN is high and 1 in the first cycle after.
  - Reset mid-stream discards all in-flight words.
- When WIDTH is a power of two, no shift is out of range and rangeErrOUT is constant 0.

Optional Feature:
- Macro: STREAM_ROTATOR_AUTO_ROTATE_EN.
- Defined:
  - Adds the autoIN port and a SHIFT_W-bit step counter, reset to 0.
  - When autoIN = 1, the counter value replaces shiftIN for the accepted word.
  - The counter increments on every accepted word while autoIN = 1 and wraps WIDTH-1 -> 0.
  - The counter holds when autoIN = 0.
  - Purpose: chase/scroll LED effects without host updates.
- Undefined: no autoIN port, no counter; shiftIN is always used.

Decomposition:
- Package stream_rotator_pkg:
  - rot_dir_t enum (ROT_LEFT = 0, ROT_RIGHT = 1).
  - Stage-payload struct typedef.
  - Normalisation function (n, dir, WIDTH) -> {e, err}.
- Sub-module rotator_stage:
  - One registered, conditional rotate-left-by-constant stage with valid/ready handshake.
  - Parametrised by WIDTH and STEP = 2^k; instantiated SHIFT_W times in a generate loop.

Test Plan:
- Reset: rstIN high 2 cycles while 3 words are in flight -> validOUT = 0, dataOUT = 0, busyOUT = 0, readyOUT = 0 during reset; none of the 3 words ever emerges.
- Left rotate, WIDTH = 24, readyIN = 1:
  - 24'h000001 shift 1 -> 24'h000002 exactly 5 cycles after accept.
  - 24'h000001 shift 23 -> 24'h800000.
  - 24'hABCDEF shift 8 -> 24'hCDEFAB.
- Right rotate: 24'h000001 shift 1 dirIN = 1 -> 24'h800000; 24'hABCDEF shift 0 dirIN = 1 -> 24'hABCDEF.
- Out of range: 24'h123456 with shift 24, then shift 31 -> dataOUT = 24'h123456 both times with rangeErrOUT = 1; the following valid-shift word has rangeErrOUT = 0.
- Backpressure: 8 back-to-back words, readyIN low for 3 cycles starting when the first word emerges -> outputs in order with no loss or duplication; readyOUT low once the pipe fills; 1 word/cycle resumes on release.
- With STREAM_ROTATOR_AUTO_ROTATE_EN, autoIN = 1, four 24'h000001 words -> 24'h000001, 000002, 000004, 000008; after 24 accepted words the counter wraps and the 25th word emerges unrotated.

Source files
------------

// File: rtl/stream_rotator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_rotator_pkg
// Brief    : Shared types and shift-normalisation helper for stream_rotator.
// Revision : 1.0 - initial release
// ============================================================================
package stream_rotator_pkg;

    localparam int c_NORM_W = 32;

    typedef enum logic {
        ROT_LEFT  = 1'b0,
        ROT_RIGHT = 1'b1
    } rot_dir_t;

    // Per-stage control payload; data and amount widths depend on WIDTH.
    typedef struct packed {
        logic valid;
        logic err;
    } stage_flags_t;

    typedef struct packed {
        logic                err;
        logic [c_NORM_W-1:0] amount;
    } norm_t;

    // Converts a requested rotate into an equivalent left-rotate amount.
    function automatic norm_t normalise_shift(
        input logic [c_NORM_W-1:0] n,
        input rot_dir_t            dir,
        input logic [c_NORM_W-1:0] width
    );
        norm_t r;
        r.err    = 1'b0;
        r.amount = '0;
        if (n >= width) begin
            r.err = 1'b1;
        end else if (dir == ROT_RIGHT && n != '0) begin
            r.amount = width - n;
        end else begin
            r.amount = n;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_rotator_stage.sv
`default_nettype none
// ============================================================================
// Module   : rotator_stage
// Brief    : One registered pipeline stage that conditionally rotates left by
//            the constant STEP, with a bubble-collapsing valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rotator_stage
    import stream_rotator_pkg::*;
#(
    parameter int WIDTH   = 24,
    parameter int SHIFT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHIFT_W-1:0] i_e,
    input  logic               i_err,
    output logic               o_up_ready,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_data,
    output logic [SHIFT_W-1:0] o_e,
    output logic               o_err,
    input  logic               i_dn_ready
);

    localparam int c_BIT = $clog2(STEP);

    stage_flags_t       r_flags;
    logic [WIDTH-1:0]   r_data;
    logic [SHIFT_W-1:0] r_e;
    logic [WIDTH-1:0]   w_rot;

    // Load whenever the register is empty or its word leaves this cycle.
    assign o_up_ready = !r_flags.valid || i_dn_ready;

    assign w_rot = i_e[c_BIT] ? {i_data[WIDTH-STEP-1:0], i_data[WIDTH-1:WIDTH-STEP]}
                              : i_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
            r_data  <= '0;
            r_e     <= '0;
        end else if (o_up_ready) begin
            r_flags.valid <= i_valid;
            if (i_valid) begin
                r_data      <= w_rot;
                r_e         <= i_e;
                r_flags.err <= i_err;
            end
        end
    end

    assign o_valid = r_flags.valid;
    assign o_data  = r_data;
    assign o_e     = r_e;
    assign o_err   = r_flags.err;

endmodule
`default_nettype wire

// File: rtl/stream_rotator.sv
`default_nettype none
// ============================================================================
// Module   : stream_rotator
// Brief    : Pipelined WIDTH-bit left/right rotator with valid/ready streaming,
//            one rotate-by-2^k stage per register. Optional feature macro:
//            STREAM_ROTATOR_AUTO_ROTATE_EN (adds autoIN and a step counter).
// Revision : 1.0 - initial release
// ============================================================================
module stream_rotator
    import stream_rotator_pkg::*;
#(
    parameter  int WIDTH   = 24,
    localparam int SHIFT_W = $clog2(WIDTH)
) (
    input  logic               clkIN,
    input  logic               rstIN,
`ifdef STREAM_ROTATOR_AUTO_ROTATE_EN
    input  logic               autoIN,
`endif
    input  logic [WIDTH-1:0]   dataIN,
    input  logic [SHIFT_W-1:0] shiftIN,
    input  logic               dirIN,
    input  logic               validIN,
    output logic               readyOUT,
    output logic [WIDTH-1:0]   dataOUT,
    output logic               validOUT,
    input  logic               readyIN,
    output logic               rangeErrOUT,
    output logic               busyOUT
);

    // Index k is the input of stage k; index SHIFT_W is the pipe output.
    logic [WIDTH-1:0]   w_data  [0:SHIFT_W];
    logic [SHIFT_W-1:0] w_e     [0:SHIFT_W];
    logic               w_err   [0:SHIFT_W];
    logic               w_valid [0:SHIFT_W];
    logic               w_ready [0:SHIFT_W];

    logic [SHIFT_W-1:0] w_n;
    norm_t              w_norm;
    logic               w_accept;
    logic               w_unused;

    assign readyOUT = !rstIN && w_ready[0];
    assign w_accept = validIN && readyOUT;

`ifdef STREAM_ROTATOR_AUTO_ROTATE_EN
    logic [SHIFT_W-1:0] r_step;

    always_ff @(posedge clkIN) begin
        if (rstIN) begin
            r_step <= '0;
        end else if (w_accept && autoIN) begin
            r_step <= (r_step == SHIFT_W'(WIDTH - 1)) ? '0 : r_step + SHIFT_W'(1);
        end
    end

    assign w_n = autoIN ? r_step : shiftIN;
`else
    assign w_n = shiftIN;
`endif

    assign w_norm     = normalise_shift(c_NORM_W'(w_n), rot_dir_t'(dirIN), c_NORM_W'(WIDTH));
    assign w_valid[0] = validIN;
    assign w_data[0]  = dataIN;
    assign w_e[0]     = w_norm.amount[SHIFT_W-1:0];
    assign w_err[0]   = w_norm.err;
    assign w_ready[SHIFT_W] = readyIN;

    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        rotator_stage #(
            .WIDTH   (WIDTH),
            .SHIFT_W (SHIFT_W),
            .STEP    (1 << k)
        ) u_stage (
            .clk        (clkIN),
            .rst        (rstIN),
            .i_valid    (w_valid[k]),
            .i_data     (w_data[k]),
            .i_e        (w_e[k]),
            .i_err      (w_err[k]),
            .o_up_ready (w_ready[k]),
            .o_valid    (w_valid[k+1]),
            .o_data     (w_data[k+1]),
            .o_e        (w_e[k+1]),
            .o_err      (w_err[k+1]),
            .i_dn_ready (w_ready[k+1])
        );
    end

    assign dataOUT  = w_data[SHIFT_W];
    assign validOUT = w_valid[SHIFT_W];

    // A power-of-two width cannot express an out-of-range amount.
    if ((1 << SHIFT_W) == WIDTH) begin : g_err_const
        assign rangeErrOUT = 1'b0;
    end else begin : g_err_live
        assign rangeErrOUT = w_err[SHIFT_W];
    end

    always_comb begin
        busyOUT = 1'b0;
        for (int k = 1; k <= SHIFT_W; k++) begin
            busyOUT = busyOUT | w_valid[k];
        end
    end

    assign w_unused = ^{w_norm.amount[c_NORM_W-1:SHIFT_W], w_e[SHIFT_W], w_err[SHIFT_W]};

endmodule
`default_nettype wire
